// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and types for the forwarding/hazard controller.
// Operand-mux select encodings and the default register-index width.
package fwd_hazard_unit_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_MEMWB   = 2'b01,
        FWD_EXMEM   = 2'b10,
        FWD_UNUSED  = 2'b11
    } fwd_sel_e;

    // Raw select values for use on plain logic [1:0] ports.
    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_MEMWB   = 2'b01;
    localparam logic [1:0] SEL_EXMEM   = 2'b10;

endpackage

// File: rtl/fwd_hazard_unit_sel_cmp.sv
// Combinational operand-select for one ALU source (instanced once for A and once for B).
// The youngest in-flight producer wins: the instruction now in EX beats the one in MEM.
module fwd_sel_cmp
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic              uses,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr,
    output logic [1:0]        sel
);

    always_comb begin
        sel = SEL_REGFILE;
        if (uses && (src != '0)) begin
            if (ex_wr && (src == ex_rd)) begin
                sel = SEL_EXMEM;
            end else if (mem_wr && (src == mem_rd)) begin
                sel = SEL_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding/hazard controller for the 5-stage pipeline: shadow EX/MEM destination tracking,
// registered operand selects, load-use stall and EX bubble. Optional macro: HAZ_STAT_EN.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic              ex_bubble_o
`ifdef HAZ_STAT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       fwd_cnt_o
`endif
);

    // Shadow copies of the destination info for the instructions in EX and MEM.
    // The WB stage is not tracked: the write-first regfile covers the WB-to-ID case.
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;

    logic ex_wr;
    logic mem_wr;
    logic rs_hit_load;
    logic rt_hit_load;
    logic stall_cond;
    logic bubble;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    assign ex_wr  = ex_valid  & ex_regwrite  & (ex_rd  != '0);
    assign mem_wr = mem_valid & mem_regwrite & (mem_rd != '0);

    // A load in EX cannot be forwarded yet; hold the consumer one cycle so it meets MEM/WB data.
    assign rs_hit_load = id_uses_rs_i & (id_rs_i == ex_rd);
    assign rt_hit_load = id_uses_rt_i & (id_rt_i == ex_rd);
    assign stall_cond  = id_valid_i & ~flush_i & ex_valid & ex_memread & (ex_rd != '0)
                       & (rs_hit_load | rt_hit_load);

    assign bubble      = flush_i | stall_cond | ~id_valid_i;
    assign stall_o     = rst_i & stall_cond;
    assign ex_bubble_o = rst_i & bubble;

    fwd_sel_cmp #(.REG_AW(REG_AW)) u_sel_a (
        .src    (id_rs_i),
        .uses   (id_uses_rs_i),
        .ex_rd  (ex_rd),
        .ex_wr  (ex_wr),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .sel    (sel_a)
    );

    fwd_sel_cmp #(.REG_AW(REG_AW)) u_sel_b (
        .src    (id_rt_i),
        .uses   (id_uses_rt_i),
        .ex_rd  (ex_rd),
        .ex_wr  (ex_wr),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .sel    (sel_b)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
        end else begin
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end else begin
                ex_valid    <= 1'b1;
                ex_rd       <= id_rd_i;
                ex_regwrite <= id_regwrite_i;
                ex_memread  <= id_memread_i;
            end
        end
    end

    // Selects are captured as the instruction enters EX, so they line up with its operands.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_a_sel_o <= SEL_REGFILE;
            fwd_b_sel_o <= SEL_REGFILE;
        end else if (bubble) begin
            fwd_a_sel_o <= SEL_REGFILE;
            fwd_b_sel_o <= SEL_REGFILE;
        end else begin
            fwd_a_sel_o <= sel_a;
            fwd_b_sel_o <= sel_b;
        end
    end

`ifdef HAZ_STAT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else begin
            if (stall_cond) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (!bubble && ((sel_a != SEL_REGFILE) || (sel_b != SEL_REGFILE))) begin
                fwd_cnt_o <= fwd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus randomized bench for fwd_hazard_unit; expectations come from an issue-history
// model: find the youngest older instruction that writes the source register.
module tb_fwd_hazard_unit;

    localparam int AW = 5;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
    } ent_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic          id_valid_i;
    logic [AW-1:0] id_rs_i;
    logic [AW-1:0] id_rt_i;
    logic          id_uses_rs_i;
    logic          id_uses_rt_i;
    logic [AW-1:0] id_rd_i;
    logic          id_regwrite_i;
    logic          id_memread_i;
    logic          flush_i;
    logic [1:0]    fwd_a_sel_o;
    logic [1:0]    fwd_b_sel_o;
    logic          stall_o;
    logic          ex_bubble_o;

    fwd_hazard_unit #(.REG_AW(AW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_uses_rs_i  (id_uses_rs_i),
        .id_uses_rt_i  (id_uses_rt_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_a_sel_o   (fwd_a_sel_o),
        .fwd_b_sel_o   (fwd_b_sel_o),
        .stall_o       (stall_o),
        .ex_bubble_o   (ex_bubble_o)
    );

    int checks = 0;
    int errors = 0;

    // issued-instruction history, newest first (index 0 = now in EX, 1 = now in MEM)
    ent_t hist[$];
    logic last_stall;
    logic last_bubble;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t hist_at(input int i);
        ent_t z;
        z = '0;
        if (i < hist.size()) return hist[i];
        return z;
    endfunction

    function automatic logic model_stall();
        ent_t e;
        e = hist_at(0);
        if (!id_valid_i || flush_i) return 1'b0;
        if (!(e.valid && e.mr && e.rd != 0)) return 1'b0;
        return (id_uses_rs_i && id_rs_i == e.rd) || (id_uses_rt_i && id_rt_i == e.rd);
    endfunction

    function automatic logic [1:0] model_sel(input logic [AW-1:0] s, input logic uses);
        ent_t e;
        if (!uses || s == 0) return 2'b00;
        for (int d = 0; d < 2; d++) begin
            e = hist_at(d);
            if (e.valid && e.rw && e.rd == s) return (d == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    // driver tasks
    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic urs, input logic urt, input logic [AW-1:0] rd,
                         input logic rw, input logic mr, input logic fl);
        id_valid_i    = v;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_uses_rs_i  = urs;
        id_uses_rt_i  = urt;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
    endtask

    // Called at a falling edge with inputs already driven; ends at the next falling edge.
    task automatic step(input string tag);
        logic       es;
        logic       eb;
        logic [1:0] ea;
        logic [1:0] ebs;
        ent_t       ent;
        #1;
        es = model_stall();
        eb = es || flush_i || !id_valid_i;
        last_stall  = stall_o;
        last_bubble = ex_bubble_o;
        chk({tag, "_stall"}, {31'd0, stall_o}, {31'd0, es});
        chk({tag, "_bubble"}, {31'd0, ex_bubble_o}, {31'd0, eb});
        ea  = eb ? 2'b00 : model_sel(id_rs_i, id_uses_rs_i);
        ebs = eb ? 2'b00 : model_sel(id_rt_i, id_uses_rt_i);
        ent = '0;
        if (!eb) ent = '{valid: 1'b1, rd: id_rd_i, rw: id_regwrite_i, mr: id_memread_i};
        @(posedge clk);
        hist.push_front(ent);
        while (hist.size() > 2) void'(hist.pop_back());
        #1;
        chk({tag, "_sel_a"}, {30'd0, fwd_a_sel_o}, {30'd0, ea});
        chk({tag, "_sel_b"}, {30'd0, fwd_b_sel_o}, {30'd0, ebs});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step("idle");
        end
    endtask

    // Asserted at a falling edge: all tracking must vanish without waiting for a clock.
    task automatic mid_reset(input string tag);
        rst_i = 1'b0;
        #1;
        chk({tag, "_rst_a"}, {30'd0, fwd_a_sel_o}, 32'd0);
        chk({tag, "_rst_b"}, {30'd0, fwd_b_sel_o}, 32'd0);
        chk({tag, "_rst_stall"}, {31'd0, stall_o}, 32'd0);
        chk({tag, "_rst_bubble"}, {31'd0, ex_bubble_o}, 32'd0);
        hist.delete();
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_sel_a", {30'd0, fwd_a_sel_o}, 32'd0);
        chk("reset_sel_b", {30'd0, fwd_b_sel_o}, 32'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        chk("reset_bubble", {31'd0, ex_bubble_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        idle(2);

        // 1: add r3 ; add r4 = r3 + r1
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0); step("t1_p");
        drive(1, 3, 1, 1, 1, 4, 1, 0, 0); step("t1_c");
        chk("t1_a_exmem", {30'd0, fwd_a_sel_o}, 32'd2);
        chk("t1_b_regfile", {30'd0, fwd_b_sel_o}, 32'd0);
        chk("t1_no_stall", {31'd0, last_stall}, 32'd0);
        idle(3);

        // 2: add r3 ; nop ; sub r5 = r1 - r3, then r3 in both EX/MEM and MEM/WB
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0); step("t2_p");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("t2_nop");
        drive(1, 1, 3, 1, 1, 5, 1, 0, 0); step("t2_c");
        chk("t2_b_memwb", {30'd0, fwd_b_sel_o}, 32'd1);
        chk("t2_a_regfile", {30'd0, fwd_a_sel_o}, 32'd0);
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0); step("t2_p1");
        drive(1, 2, 2, 1, 1, 3, 1, 0, 0); step("t2_p2");
        drive(1, 1, 3, 1, 1, 5, 1, 0, 0); step("t2_c2");
        chk("t2_newest_wins", {30'd0, fwd_b_sel_o}, 32'd2);
        idle(3);

        // 3: lw r2 ; add r6 = r2 + r2
        drive(1, 1, 0, 1, 0, 2, 1, 1, 0); step("t3_ld");
        drive(1, 2, 2, 1, 1, 6, 1, 0, 0); step("t3_stall");
        chk("t3_stall_hi", {31'd0, last_stall}, 32'd1);
        chk("t3_bubble_hi", {31'd0, last_bubble}, 32'd1);
        step("t3_go");
        chk("t3_stall_lo", {31'd0, last_stall}, 32'd0);
        chk("t3_a_memwb", {30'd0, fwd_a_sel_o}, 32'd1);
        chk("t3_b_memwb", {30'd0, fwd_b_sel_o}, 32'd1);
        idle(3);

        // 4: writes to r0 are never forwarded and never cause a stall
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0); step("t4_p");
        drive(1, 0, 0, 1, 1, 7, 1, 0, 0); step("t4_c");
        chk("t4_a_r0", {30'd0, fwd_a_sel_o}, 32'd0);
        chk("t4_b_r0", {30'd0, fwd_b_sel_o}, 32'd0);
        drive(1, 1, 0, 1, 0, 0, 1, 1, 0); step("t4_ld");
        drive(1, 0, 0, 1, 1, 7, 1, 0, 0); step("t4_use");
        chk("t4_no_stall", {31'd0, last_stall}, 32'd0);
        idle(3);

        // 5: flush beats stall; then async reset with forwarding in flight
        drive(1, 1, 0, 1, 0, 2, 1, 1, 0); step("t5_ld");
        drive(1, 2, 2, 1, 1, 6, 1, 0, 1); step("t5_flush");
        chk("t5_flush_stall", {31'd0, last_stall}, 32'd0);
        chk("t5_flush_bubble", {31'd0, last_bubble}, 32'd1);
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0); step("t5_p");
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0); step("t5_c");
        chk("t5_pre_rst_a", {30'd0, fwd_a_sel_o}, 32'd2);
        drive(1, 4, 3, 1, 1, 5, 1, 0, 0);
        mid_reset("t5");
        idle(1);

        // randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            if (i == 250) begin
                mid_reset("rnd");
            end else if (last_stall && $urandom_range(0, 3) != 0) begin
                flush_i = ($urandom_range(0, 7) == 0);
                step("rnd");
            end else begin
                drive($urandom_range(0, 9) != 0,
                      AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 3)),
                      $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) == 0);
                step("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
